// File: rtl/risc_pkg.sv
// Shared encodings for the 16-bit RISC pipeline: EX op codes,
// the MEM stage FSM states and the "no writeback" register index.
package risc_pkg;

  typedef enum logic [1:0] {
    OP_ALU   = 2'd0,
    OP_LOAD  = 2'd1,
    OP_STORE = 2'd2,
    OP_LB    = 2'd3
  } op_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_e;

  localparam logic [2:0] NO_REG = 3'd0;

endpackage

// File: rtl/mem_access_stage.sv
// Memory-access stage: passes ALU/LB results through in one cycle and runs
// LOAD/STORE on a variable-latency data port, stalling upstream meanwhile.
module mem_access_stage
  import risc_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic [1:0]  ex_op,
  input  logic [15:0] ex_alu_out,
  input  logic [15:0] ex_store_data,
  input  logic [7:0]  ex_lb_const,
  input  logic [2:0]  ex_fwd_reg,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [15:0] dmem_addr,
  output logic [15:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [15:0] dmem_rdata,
  output logic        mem_valid,
  output logic [15:0] mem_mem_out,
  output logic [15:0] mem_alu_out,
  output logic [7:0]  mem_lb_const,
  output logic [2:0]  mem_fwd_reg,
  output logic        mem_err
);

  localparam logic [7:0] TIMEOUT_W = 8'(TIMEOUT);

  mem_state_e  state;
  logic [7:0]  wait_cnt;
  logic [7:0]  wait_next;
  logic [1:0]  lat_op;
  logic [7:0]  lat_lb_const;
  logic [2:0]  lat_fwd_reg;
  logic        is_mem_op;
  logic        timeout_hit;

  // The request is abandoned in the BUSY cycle whose increment brings the
  // counter to TIMEOUT, so dmem_req is high for exactly TIMEOUT cycles.
  always_comb begin
    is_mem_op   = (ex_op == OP_LOAD) || (ex_op == OP_STORE);
    wait_next   = (wait_cnt == TIMEOUT_W) ? wait_cnt : wait_cnt + 8'd1;
    timeout_hit = (state == BUSY) && (wait_next == TIMEOUT_W);
    stall       = reset &&
                  (((state == IDLE) && ex_valid && is_mem_op) ||
                   ((state == BUSY) && !dmem_ack && !timeout_hit));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      wait_cnt     <= 8'd0;
      lat_op       <= 2'd0;
      lat_lb_const <= 8'd0;
      lat_fwd_reg  <= NO_REG;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= 16'd0;
      dmem_wdata   <= 16'd0;
      mem_valid    <= 1'b0;
      mem_mem_out  <= 16'd0;
      mem_alu_out  <= 16'd0;
      mem_lb_const <= 8'd0;
      mem_fwd_reg  <= NO_REG;
      mem_err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!ex_valid) begin
            mem_valid   <= 1'b0;
            mem_fwd_reg <= NO_REG;
          end else if (is_mem_op) begin
            state        <= BUSY;
            wait_cnt     <= 8'd0;
            lat_op       <= ex_op;
            lat_lb_const <= ex_lb_const;
            lat_fwd_reg  <= ex_fwd_reg;
            dmem_req     <= 1'b1;
            dmem_we      <= (ex_op == OP_STORE);
            dmem_addr    <= ex_alu_out;
            dmem_wdata   <= ex_store_data;
            mem_valid    <= 1'b0;
            mem_fwd_reg  <= NO_REG;
          end else begin
            mem_valid    <= 1'b1;
            mem_alu_out  <= ex_alu_out;
            mem_lb_const <= ex_lb_const;
            mem_fwd_reg  <= ex_fwd_reg;
            mem_mem_out  <= 16'd0;
          end
        end
        BUSY: begin
          wait_cnt <= wait_next;
          // Ack takes priority over a timeout landing in the same cycle.
          if (dmem_ack) begin
            state        <= IDLE;
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            mem_valid    <= 1'b1;
            mem_alu_out  <= dmem_addr;
            mem_lb_const <= lat_lb_const;
            if (lat_op == OP_LOAD) begin
              mem_mem_out <= dmem_rdata;
              mem_fwd_reg <= lat_fwd_reg;
            end else begin
              mem_mem_out <= 16'd0;
              mem_fwd_reg <= NO_REG;
            end
          end else if (timeout_hit) begin
            state        <= IDLE;
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            mem_err      <= 1'b1;
            mem_valid    <= 1'b1;
            mem_alu_out  <= dmem_addr;
            mem_lb_const <= lat_lb_const;
            mem_mem_out  <= 16'd0;
            mem_fwd_reg  <= NO_REG;
          end else begin
            mem_valid   <= 1'b0;
            mem_fwd_reg <= NO_REG;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage (TIMEOUT=4): pass-through, loads,
// stores, timeout, ack-at-timeout and reset in the middle of an access.
module tb_mem_access_stage;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        ex_valid = 1'b0;
  logic [1:0]  ex_op = 2'd0;
  logic [15:0] ex_alu_out = 16'd0;
  logic [15:0] ex_store_data = 16'd0;
  logic [7:0]  ex_lb_const = 8'd0;
  logic [2:0]  ex_fwd_reg = 3'd0;
  logic        stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [15:0] dmem_addr;
  logic [15:0] dmem_wdata;
  logic        dmem_ack = 1'b0;
  logic [15:0] dmem_rdata = 16'd0;
  logic        mem_valid;
  logic [15:0] mem_mem_out;
  logic [15:0] mem_alu_out;
  logic [7:0]  mem_lb_const;
  logic [2:0]  mem_fwd_reg;
  logic        mem_err;

  int checks = 0;
  int errors = 0;

  mem_access_stage #(.TIMEOUT(4)) dut (
    .clock(clock), .reset(reset),
    .ex_valid(ex_valid), .ex_op(ex_op), .ex_alu_out(ex_alu_out),
    .ex_store_data(ex_store_data), .ex_lb_const(ex_lb_const), .ex_fwd_reg(ex_fwd_reg),
    .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .mem_valid(mem_valid), .mem_mem_out(mem_mem_out), .mem_alu_out(mem_alu_out),
    .mem_lb_const(mem_lb_const), .mem_fwd_reg(mem_fwd_reg), .mem_err(mem_err)
  );

  always #5 clock = ~clock;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic present(input logic [1:0] op, input logic [15:0] alu,
                         input logic [15:0] sdata, input logic [7:0] lb,
                         input logic [2:0] fwd);
    ex_valid = 1'b1; ex_op = op; ex_alu_out = alu;
    ex_store_data = sdata; ex_lb_const = lb; ex_fwd_reg = fwd;
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({stall, dmem_req, dmem_we, dmem_addr, dmem_wdata, mem_valid, mem_mem_out,
         mem_alu_out, mem_lb_const, mem_fwd_reg, mem_err} !== '0) begin
      errors++; $display("FAIL reset_outputs: got nonzero outputs, required all 0");
    end
    tick(); tick();
    reset = 1'b1;
    tick();
    checks++;
    if (mem_valid !== 1'b0 || stall !== 1'b0) begin
      errors++; $display("FAIL reset_release: mem_valid=%b stall=%b, required 0 0", mem_valid, stall);
    end
    $display("reset: outputs cleared");
  endtask

  task automatic test_alu();
    present(2'd0, 16'h1234, 16'h0000, 8'h77, 3'd5);
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL alu_stall: got %b required 0", stall); end
    tick();
    // LB follows immediately: throughput one per cycle
    present(2'd3, 16'h5678, 16'h0000, 8'h9A, 3'd2);
    checks++;
    if (mem_valid !== 1'b1 || mem_alu_out !== 16'h1234 || mem_fwd_reg !== 3'd5 ||
        mem_lb_const !== 8'h77 || mem_mem_out !== 16'h0000 || stall !== 1'b0) begin
      errors++;
      $display("FAIL alu_retire: valid=%b alu=%h fwd=%0d lb=%h mem=%h stall=%b required 1 1234 5 77 0000 0",
               mem_valid, mem_alu_out, mem_fwd_reg, mem_lb_const, mem_mem_out, stall);
    end
    tick();
    ex_valid = 1'b0;
    checks++;
    if (mem_valid !== 1'b1 || mem_alu_out !== 16'h5678 || mem_lb_const !== 8'h9A || mem_fwd_reg !== 3'd2) begin
      errors++;
      $display("FAIL lb_retire: valid=%b alu=%h lb=%h fwd=%0d required 1 5678 9a 2",
               mem_valid, mem_alu_out, mem_lb_const, mem_fwd_reg);
    end
    tick();
    checks++;
    if (mem_valid !== 1'b0 || mem_fwd_reg !== 3'd0 || mem_alu_out !== 16'h5678) begin
      errors++;
      $display("FAIL idle_bubble: valid=%b fwd=%0d alu=%h required 0 0 5678", mem_valid, mem_fwd_reg, mem_alu_out);
    end
    $display("alu/lb: pass-through 1234/5678");
  endtask

  task automatic test_load();
    int stall_cycles = 0;
    present(2'd1, 16'h0040, 16'h0000, 8'h12, 3'd3);
    if (stall) stall_cycles++;
    tick();
    checks++;
    if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== 16'h0040) begin
      errors++;
      $display("FAIL load_req: req=%b we=%b addr=%h required 1 0 0040", dmem_req, dmem_we, dmem_addr);
    end
    if (stall) stall_cycles++;
    tick();
    if (stall) stall_cycles++;
    tick();
    dmem_ack = 1'b1; dmem_rdata = 16'hBEEF;
    #1;
    if (stall) stall_cycles++;
    checks++;
    if (stall_cycles != 3) begin
      errors++; $display("FAIL load_stall_len: got %0d cycles required 3", stall_cycles);
    end
    tick();
    dmem_ack = 1'b0; ex_valid = 1'b0;
    checks++;
    if (mem_valid !== 1'b1 || mem_mem_out !== 16'hBEEF || mem_fwd_reg !== 3'd3 ||
        mem_alu_out !== 16'h0040 || mem_lb_const !== 8'h12 || dmem_req !== 1'b0) begin
      errors++;
      $display("FAIL load_retire: valid=%b mem=%h fwd=%0d alu=%h lb=%h req=%b required 1 beef 3 0040 12 0",
               mem_valid, mem_mem_out, mem_fwd_reg, mem_alu_out, mem_lb_const, dmem_req);
    end
    tick();
    checks++;
    if (mem_valid !== 1'b0) begin errors++; $display("FAIL load_pulse: valid=%b required 0", mem_valid); end
    $display("load: addr 0040 data beef after 3 stall cycles");
  endtask

  task automatic test_store();
    present(2'd2, 16'h0010, 16'hA5A5, 8'h00, 3'd6);
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL store_accept_stall: got %b required 1", stall); end
    tick();
    dmem_ack = 1'b1;
    #1;
    checks++;
    if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_wdata !== 16'hA5A5 ||
        dmem_addr !== 16'h0010 || stall !== 1'b0) begin
      errors++;
      $display("FAIL store_req: req=%b we=%b wdata=%h addr=%h stall=%b required 1 1 a5a5 0010 0",
               dmem_req, dmem_we, dmem_wdata, dmem_addr, stall);
    end
    tick();
    dmem_ack = 1'b0; ex_valid = 1'b0;
    checks++;
    if (mem_valid !== 1'b1 || mem_fwd_reg !== 3'd0 || mem_mem_out !== 16'h0000 ||
        mem_alu_out !== 16'h0010 || dmem_we !== 1'b0 || dmem_req !== 1'b0) begin
      errors++;
      $display("FAIL store_retire: valid=%b fwd=%0d mem=%h alu=%h we=%b req=%b required 1 0 0000 0010 0 0",
               mem_valid, mem_fwd_reg, mem_mem_out, mem_alu_out, dmem_we, dmem_req);
    end
    tick();
    $display("store: addr 0010 data a5a5 acked first cycle");
  endtask

  task automatic test_ack_at_timeout();
    present(2'd1, 16'h0080, 16'h0000, 8'h00, 3'd2);
    tick(); tick(); tick();
    checks++;
    if (stall !== 1'b1 || dmem_req !== 1'b1) begin
      errors++; $display("FAIL ackto_wait: stall=%b req=%b required 1 1", stall, dmem_req);
    end
    tick();
    dmem_ack = 1'b1; dmem_rdata = 16'h1357;
    #1;
    tick();
    dmem_ack = 1'b0; ex_valid = 1'b0;
    checks++;
    if (mem_valid !== 1'b1 || mem_mem_out !== 16'h1357 || mem_fwd_reg !== 3'd2 || mem_err !== 1'b0) begin
      errors++;
      $display("FAIL ackto_retire: valid=%b mem=%h fwd=%0d err=%b required 1 1357 2 0",
               mem_valid, mem_mem_out, mem_fwd_reg, mem_err);
    end
    tick();
    $display("ack_at_timeout: completed normally, err=%b", mem_err);
  endtask

  task automatic test_timeout();
    int req_cycles = 0;
    present(2'd1, 16'h00C0, 16'h0000, 8'h00, 3'd4);
    tick();
    for (int i = 0; i < 4; i++) begin
      if (dmem_req) req_cycles++;
      checks++;
      if (stall !== (i < 3)) begin
        errors++; $display("FAIL timeout_stall_%0d: got %b required %b", i, stall, (i < 3));
      end
      if (i == 3) ex_valid = 1'b0;
      tick();
    end
    if (dmem_req) req_cycles++;
    checks++;
    if (req_cycles != 4) begin errors++; $display("FAIL timeout_req_len: got %0d required 4", req_cycles); end
    checks++;
    if (mem_valid !== 1'b1 || mem_fwd_reg !== 3'd0 || mem_mem_out !== 16'h0000 || mem_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_retire: valid=%b fwd=%0d mem=%h err=%b required 1 0 0000 1",
               mem_valid, mem_fwd_reg, mem_mem_out, mem_err);
    end
    tick();
    // a later acked load still completes; error stays sticky
    present(2'd1, 16'h0100, 16'h0000, 8'h00, 3'd7);
    tick();
    dmem_ack = 1'b1; dmem_rdata = 16'h2468;
    #1;
    tick();
    dmem_ack = 1'b0; ex_valid = 1'b0;
    checks++;
    if (mem_valid !== 1'b1 || mem_mem_out !== 16'h2468 || mem_fwd_reg !== 3'd7 || mem_err !== 1'b1) begin
      errors++;
      $display("FAIL post_timeout_load: valid=%b mem=%h fwd=%0d err=%b required 1 2468 7 1",
               mem_valid, mem_mem_out, mem_fwd_reg, mem_err);
    end
    tick();
    $display("timeout: req high %0d cycles, err=%b", req_cycles, mem_err);
  endtask

  task automatic test_reset_mid_access();
    present(2'd1, 16'h0200, 16'h0000, 8'h00, 3'd1);
    tick(); tick();
    checks++;
    if (dmem_req !== 1'b1 || stall !== 1'b1) begin
      errors++; $display("FAIL midrst_busy: req=%b stall=%b required 1 1", dmem_req, stall);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (dmem_req !== 1'b0 || stall !== 1'b0 || mem_valid !== 1'b0 || mem_err !== 1'b0) begin
      errors++;
      $display("FAIL midrst_drop: req=%b stall=%b valid=%b err=%b required 0 0 0 0",
               dmem_req, stall, mem_valid, mem_err);
    end
    ex_valid = 1'b0;
    tick(); tick();
    reset = 1'b1;
    present(2'd0, 16'hCAFE, 16'h0000, 8'h00, 3'd5);
    checks++;
    if (mem_valid !== 1'b0 || stall !== 1'b0) begin
      errors++; $display("FAIL midrst_idle: valid=%b stall=%b required 0 0", mem_valid, stall);
    end
    tick();
    ex_valid = 1'b0;
    checks++;
    if (mem_valid !== 1'b1 || mem_alu_out !== 16'hCAFE || mem_fwd_reg !== 3'd5) begin
      errors++;
      $display("FAIL midrst_resume: valid=%b alu=%h fwd=%0d required 1 cafe 5", mem_valid, mem_alu_out, mem_fwd_reg);
    end
    tick();
    $display("reset_mid_access: request dropped, pipeline resumed");
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_ack_at_timeout();
    test_timeout();
    test_reset_mid_access();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access stage of the 16-bit RISC pipeline, between the EX/MEM register and the MEM/WB buffer. It drives the data-memory port for loads and stores and passes ALU results through unchanged. It stalls the upstream pipeline while a variable-latency memory access is outstanding. It produces the `mem_*` operand set that the MEM/WB buffer registers for writeback.

## Interface
Parameters:
- `TIMEOUT`, default 15: maximum BUSY cycles waiting for `dmem_ack` before the access is abandoned (1..255).

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset (asserts immediately, deasserts synchronously to `clock`).
- `ex_valid` in 1: EX/MEM holds a real instruction.
- `ex_op` in 2: 0 = ALU, 1 = LOAD, 2 = STORE, 3 = LB (load-byte constant, no memory access).
- `ex_alu_out` in 16: ALU result, or effective address for LOAD/STORE.
- `ex_store_data` in 16: STORE write data.
- `ex_lb_const` in 8: load-byte constant.
- `ex_fwd_reg` in 3: destination register.
- `stall` out 1: hold EX/MEM and earlier stages.
- `dmem_req`, `dmem_we` out 1: memory request and write enable.
- `dmem_addr`, `dmem_wdata` out 16: memory address and write data.
- `dmem_ack` in 1: memory completes the request this cycle.
- `dmem_rdata` in 16: load data, valid with `dmem_ack`.
- `mem_valid` out 1: the `mem_*` outputs hold a retired instruction this cycle.
- `mem_mem_out`, `mem_alu_out` out 16: to MEM/WB.
- `mem_lb_const` out 8: to MEM/WB.
- `mem_fwd_reg` out 3: to MEM/WB.
- `mem_err` out 1: sticky flag, set when any access times out.

## Operation
- FSM states are IDLE and BUSY. Reset enters IDLE.
- In IDLE with `ex_valid=0`:
  - next-cycle `mem_valid=0` and `mem_fwd_reg=0`;
  - other `mem_*` outputs hold.
- In IDLE with `ex_valid=1` and op ALU or LB:
  - register `mem_alu_out=ex_alu_out`, `mem_lb_const=ex_lb_const`, `mem_fwd_reg=ex_fwd_reg`, `mem_mem_out=0`, `mem_valid=1`;
  - `stall=0`.
- In IDLE with `ex_valid=1` and op LOAD or STORE:
  - `stall=1` combinationally;
  - latch address, write data, op, `lb_const` and `fwd_reg`;
  - go to BUSY;
  - `dmem_req`, `dmem_addr`, `dmem_we` (STORE) and `dmem_wdata` are registered and valid from the first BUSY cycle.
- In BUSY, `ex_*` inputs are ignored. `stall = ~dmem_ack & ~timeout_hit`.
- BUSY with `dmem_ack`:
  - next cycle `mem_valid=1`, `mem_alu_out` = latched address;
  - LOAD: `mem_mem_out=dmem_rdata`, `mem_fwd_reg` = latched reg;
  - STORE: `mem_mem_out=0`, `mem_fwd_reg=0` (no writeback);
  - `dmem_req` drops; return to IDLE.
- BUSY timeout: the wait counter reaches `TIMEOUT` without ack.
  - Drop `dmem_req` and set `mem_err`.
  - Retire the instruction with `mem_valid=1`, `mem_mem_out=0`, `mem_fwd_reg=0`.
  - Return to IDLE.
- `dmem_ack` in the same cycle as timeout: the ack wins and `mem_err` is not set.
- `dmem_ack` while IDLE is ignored.
- `mem_err` clears only on reset.
- Widths: no arithmetic on data paths. The wait counter is 8 bits, saturates at `TIMEOUT`, and clears on entry to BUSY.

## Timing
- Reset values:
  - all outputs 0;
  - state IDLE, wait counter 0;
  - `stall=0` (combinational from state).
- Reset mid-access: request dropped at once, no retirement, no error set.
- ALU/LB latency: 1 cycle from `ex_*` to `mem_*`, with throughput 1 per cycle.
- LOAD/STORE sequence:
  - cycle 0: accept, `stall=1`;
  - cycles 1..k: `dmem_req=1`, with `dmem_ack` in cycle k;
  - cycle k: `stall=0`, so upstream advances;
  - cycle k+1: `mem_valid=1`.
  - The minimum occupancy is 2 cycles, when k=1.
- Back-to-back memory ops: the next op is presented in cycle k+1, and the stall repeats.
- `dmem_*` outputs change only on `clock` edges. They are held stable while `dmem_req=1` and `dmem_ack=0`.

## Structure
- Shared package `risc_pkg` holds:
  - the `ex_op` encodings: OP_ALU, OP_LOAD, OP_STORE, OP_LB;
  - the FSM state typedef with IDLE and BUSY;
  - `NO_REG = 3'd0`.
- Single module with no sub-module. The counter and FSM are small enough to keep inline.

## Test plan
- ALU pass-through: `ex_valid=1`, OP_ALU, `alu_out=16'h1234`, `fwd_reg=5` → next cycle `mem_valid=1`, `mem_alu_out=16'h1234`, `mem_fwd_reg=5`, `stall` never asserted.
- LOAD with 3-cycle ack: `addr=16'h0040`, ack in the 3rd BUSY cycle with `rdata=16'hBEEF` → `stall` high for 3 cycles, then `mem_mem_out=16'hBEEF`, `mem_fwd_reg=ex_fwd_reg`, `mem_valid` single pulse.
- STORE with ack in the first BUSY cycle: `addr=16'h0010`, `data=16'hA5A5` → `dmem_we=1`, `dmem_wdata=16'hA5A5` for 1 cycle, then retire with `mem_fwd_reg=0`.
- Timeout, `TIMEOUT=4`, no ack → `dmem_req` high exactly 4 cycles, `mem_err=1`, retire with `mem_fwd_reg=0`. A later LOAD that is acked still completes normally with `mem_err` held at 1.
- Ack coinciding with the timeout cycle → normal completion, `mem_err=0`.
- Reset asserted in the 2nd BUSY cycle → `dmem_req` and `stall` drop immediately, state IDLE, no `mem_valid` pulse, and the pipeline resumes after reset deasserts.
